mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Main sequencer of the multi-cycle RV32 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and it owns the single shared memory port handshake. Each cycle it drives the enables for PC, IR and register-file write, plus the writeback source select consumed by the writeback mux. It sits between the decoder (which supplies the instruction class) and the datapath registers.

Parameters:
MEM_TIMEOUT, 255, max wait cycles on mem_ready_i before trap (used only with STALL_TIMEOUT_EN)
TW, 8, width of timeout counter; must satisfy 2**TW > MEM_TIMEOUT

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous reset, active-high
op_class_i  in  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP (JAL/JALR), 5 UPPER (LUI/AUIPC), 6-7 ILLEGAL
branch_taken_i  in  1  branch comparator result, valid in EXECUTE
mem_ready_i  in  1  memory response/accept, may be high in the same cycle as mem_req_o
mem_req_o  out  1  memory request
mem_we_o  out  1  store request
mem_instr_o  out  1  request is an instruction fetch
ir_we_o  out  1  load IR from memory data
pc_we_o  out  1  update PC
pc_sel_o  out  1  0 = pc+4, 1 = ALU target
rf_we_o  out  1  register-file write enable
wb_sel_o  out  2  writeback source, WB_MEM/WB_ALU/WB_PC4 encoding from the writeback enum
retire_o  out  1  1-cycle pulse when an instruction completes
trap_o  out  1  sticky halt flag
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Values 6-7 are unreachable and go to TRAP.
- Reset: state=FETCH, trap_o=0, all other outputs 0, wb_sel_o=WB_ALU, timeout counter=0. Reset asserted mid-instruction aborts it. No write or retire occurs in the reset cycle.
- All outputs are combinational from state and inputs, except trap_o, which is registered.
- FETCH:
  - mem_req_o=1, mem_instr_o=1, mem_we_o=0.
  - On mem_ready_i=1: ir_we_o=1, pc_we_o=1, pc_sel_o=0, then go to DECODE.
  - Otherwise hold state. Requests stay asserted with stable attributes until ready.
- DECODE:
  - ILLEGAL → TRAP.
  - Any other class → EXECUTE.
  - No enables asserted.
- EXECUTE, by class:
  - ALU, UPPER → WRITEBACK.
  - LOAD, STORE → MEM.
  - BRANCH: pc_we_o=branch_taken_i, pc_sel_o=1, retire_o=1, then FETCH.
  - JUMP: pc_we_o=1, pc_sel_o=1, then WRITEBACK. The link value comes from the pc_plus4 captured before the PC update.
- MEM:
  - mem_req_o=1, mem_instr_o=0, mem_we_o=1 for STORE.
  - On mem_ready_i: STORE retires (retire_o=1) and goes to FETCH; LOAD goes to WRITEBACK.
  - Otherwise hold.
- WRITEBACK:
  - rf_we_o=1, retire_o=1, then FETCH.
  - wb_sel_o: LOAD=WB_MEM, JUMP=WB_PC4, ALU/UPPER=WB_ALU.
- wb_sel_o is driven from op_class_i in all states; it is only meaningful when rf_we_o=1.
- TRAP: all enables and requests 0, trap_o=1, held until rst_i.
- Zero-wait-state cycle counts (FETCH through last state inclusive):
  - ALU/UPPER/JUMP: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each extra memory wait cycle adds 1 cycle.
- Exactly one retire_o pulse per non-illegal instruction. rf_we_o is never high outside WRITEBACK.

Optional Feature:
STALL_TIMEOUT_EN:
- Defined: a TW-bit counter increments each cycle in FETCH or MEM while mem_req_o=1 and mem_ready_i=0. It clears on any state change or handshake. When the counter reaches MEM_TIMEOUT with ready still low, the FSM enters TRAP on the next edge; mem_req_o drops and trap_o=1.
- Undefined: no counter is instantiated, and the FSM waits indefinitely for mem_ready_i.

Test Plan:
1. Reset, then ALU class with mem_ready_i tied 1 → states 0,1,2,4,0. ir_we_o and pc_we_o pulse at cycle 0; rf_we_o=1 with wb_sel_o=WB_ALU and retire_o pulse at cycle 3.
2. LOAD with ready delayed 2 cycles in both FETCH and MEM → 9 total cycles. mem_instr_o=1 during FETCH and 0 during MEM. rf_we_o with wb_sel_o=WB_MEM once.
3. STORE, then BRANCH taken, then BRANCH not-taken:
   - STORE: mem_we_o=1 in MEM, rf_we_o never asserts.
   - Taken branch: pc_we_o=1, pc_sel_o=1 in EXECUTE.
   - Not-taken branch: pc_we_o=0 in EXECUTE.
   - Each of the three produces exactly one retire_o.
4. JUMP → pc_we_o/pc_sel_o=1 in EXECUTE, then rf_we_o with wb_sel_o=WB_PC4 in WRITEBACK.
5. op_class_i=7 in DECODE → TRAP; trap_o=1 and all enables 0 for 20 cycles. Then rst_i for 1 cycle → FETCH, trap_o=0.
6. rst_i asserted while in MEM with ready low → next cycle FETCH, no retire_o, no rf_we_o. With STALL_TIMEOUT_EN and ready held 0 in FETCH → trap_o=1 after MEM_TIMEOUT+1 cycles (256 at default).

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 main sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK plus TRAP.
// Optional build macro STALL_TIMEOUT_EN adds a memory-stall watchdog that traps.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] op_class_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_instr_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_sel_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       retire_o,
  output logic       trap_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_UPPER  = 3'd5;

  if (MEM_TIMEOUT >= (1 << TW)) begin : g_bad_tw
    $error("mc_control_fsm: TW too narrow for MEM_TIMEOUT");
  end

  state_e  state_q, state_d;
  logic    trap_q, trap_d;
  logic    stall_timeout;

`ifdef STALL_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
  assign stall_timeout = (tmo_q == TMO_MAX) && !mem_ready_i;
`else
  assign stall_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_instr_o = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    rf_we_o     = 1'b0;
    retire_o    = 1'b0;
    case (op_class_i)
      OP_LOAD: wb_sel_o = WB_MEM;
      OP_JUMP: wb_sel_o = WB_PC4;
      default: wb_sel_o = WB_ALU;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        mem_instr_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (stall_timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (op_class_i > OP_UPPER) state_d = S_TRAP;
        else                       state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (op_class_i)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_we_o  = branch_taken_i;
            pc_sel_o = 1'b1;
            retire_o = 1'b1;
            state_d  = S_FETCH;
          end
          // PC moves to the jump target here; the link value was captured earlier
          OP_JUMP: begin
            pc_we_o  = 1'b1;
            pc_sel_o = 1'b1;
            state_d  = S_WRITEBACK;
          end
          OP_ALU, OP_UPPER: state_d = S_WRITEBACK;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op_class_i == OP_STORE);
        if (mem_ready_i) begin
          if (op_class_i == OP_STORE) begin
            retire_o = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (stall_timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        rf_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // The reset cycle must not leak a write, request or retire into the datapath
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_instr_o = 1'b0;
      ir_we_o     = 1'b0;
      pc_we_o     = 1'b0;
      pc_sel_o    = 1'b0;
      rf_we_o     = 1'b0;
      retire_o    = 1'b0;
      wb_sel_o    = WB_ALU;
    end

    trap_d = trap_q | (state_d == S_TRAP);
  end

`ifdef STALL_TIMEOUT_EN
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && mem_req_o && !mem_ready_i &&
        ((state_q == S_FETCH) || (state_q == S_MEM)))
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  assign trap_o  = trap_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; hand-computed state and output vectors per cycle.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op = 3'd0;
  logic       bt = 1'b0;
  logic       rdy = 1'b0;
  logic       mem_req, mem_we, mem_instr, ir_we, pc_we, pc_sel, rf_we, retire, trap;
  logic [1:0] wb_sel;
  logic [2:0] state;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk_i(clk), .rst_i(rst), .op_class_i(op), .branch_taken_i(bt),
    .mem_ready_i(rdy), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_instr_o(mem_instr), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .pc_sel_o(pc_sel), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
    .retire_o(retire), .trap_o(trap), .state_o(state)
  );

  // {req, we, instr, ir_we, pc_we, pc_sel, rf_we, wb_sel[1:0], retire, trap}
  logic [10:0] outs;
  assign outs = {mem_req, mem_we, mem_instr, ir_we, pc_we, pc_sel, rf_we, wb_sel, retire, trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, check state and outputs for this cycle, then advance one clock.
  task automatic step(input string tag, input logic [2:0] o, input logic b, input logic r,
                      input logic [2:0] exp_st, input logic [10:0] exp_o);
    op = o; bt = b; rdy = r;
    #1;
    chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_st});
    chk({tag, ".outs"}, {21'd0, outs}, {21'd0, exp_o});
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("reset.state", {29'd0, state}, 32'd0);
    chk("reset.outs", {21'd0, outs}, 32'd0);
    rst = 1'b0;

    // ALU, ready tied high
    step("alu.f", 3'd0, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_00_0_0);
    step("alu.d", 3'd0, 0, 1, 3'd1, 11'b0_0_0_0_0_0_0_00_0_0);
    step("alu.e", 3'd0, 0, 1, 3'd2, 11'b0_0_0_0_0_0_0_00_0_0);
    step("alu.w", 3'd0, 0, 1, 3'd4, 11'b0_0_0_0_0_0_1_00_1_0);

    // LOAD, two wait cycles in FETCH and in MEM: 9 cycles
    step("ld.f0", 3'd1, 0, 0, 3'd0, 11'b1_0_1_0_0_0_0_01_0_0);
    step("ld.f1", 3'd1, 0, 0, 3'd0, 11'b1_0_1_0_0_0_0_01_0_0);
    step("ld.f2", 3'd1, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_01_0_0);
    step("ld.d",  3'd1, 0, 0, 3'd1, 11'b0_0_0_0_0_0_0_01_0_0);
    step("ld.e",  3'd1, 0, 0, 3'd2, 11'b0_0_0_0_0_0_0_01_0_0);
    step("ld.m0", 3'd1, 0, 0, 3'd3, 11'b1_0_0_0_0_0_0_01_0_0);
    step("ld.m1", 3'd1, 0, 0, 3'd3, 11'b1_0_0_0_0_0_0_01_0_0);
    step("ld.m2", 3'd1, 0, 1, 3'd3, 11'b1_0_0_0_0_0_0_01_0_0);
    step("ld.w",  3'd1, 0, 1, 3'd4, 11'b0_0_0_0_0_0_1_01_1_0);

    // STORE
    step("st.f", 3'd2, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_00_0_0);
    step("st.d", 3'd2, 0, 1, 3'd1, 11'b0_0_0_0_0_0_0_00_0_0);
    step("st.e", 3'd2, 0, 1, 3'd2, 11'b0_0_0_0_0_0_0_00_0_0);
    step("st.m", 3'd2, 0, 1, 3'd3, 11'b1_1_0_0_0_0_0_00_1_0);

    // BRANCH taken, then not taken
    step("bt.f", 3'd3, 1, 1, 3'd0, 11'b1_0_1_1_1_0_0_00_0_0);
    step("bt.d", 3'd3, 1, 1, 3'd1, 11'b0_0_0_0_0_0_0_00_0_0);
    step("bt.e", 3'd3, 1, 1, 3'd2, 11'b0_0_0_0_1_1_0_00_1_0);
    step("bn.f", 3'd3, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_00_0_0);
    step("bn.d", 3'd3, 0, 1, 3'd1, 11'b0_0_0_0_0_0_0_00_0_0);
    step("bn.e", 3'd3, 0, 1, 3'd2, 11'b0_0_0_0_0_1_0_00_1_0);

    // JUMP
    step("j.f", 3'd4, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_10_0_0);
    step("j.d", 3'd4, 0, 1, 3'd1, 11'b0_0_0_0_0_0_0_10_0_0);
    step("j.e", 3'd4, 0, 1, 3'd2, 11'b0_0_0_0_1_1_0_10_0_0);
    step("j.w", 3'd4, 0, 1, 3'd4, 11'b0_0_0_0_0_0_1_10_1_0);

    // ILLEGAL traps and holds until reset
    step("il.f", 3'd7, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_00_0_0);
    step("il.d", 3'd7, 0, 1, 3'd1, 11'b0_0_0_0_0_0_0_00_0_0);
    for (int i = 0; i < 20; i++)
      step($sformatf("trap%0d", i), 3'd7, 0, 1, 3'd5, 11'b0_0_0_0_0_0_0_00_0_1);
    rst = 1'b1; rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step("trap.rst", 3'd0, 0, 0, 3'd0, 11'b1_0_1_0_0_0_0_00_0_0);

    // Reset in MEM with ready low aborts the LOAD
    step("ab.f", 3'd1, 0, 1, 3'd0, 11'b1_0_1_1_1_0_0_01_0_0);
    step("ab.d", 3'd1, 0, 0, 3'd1, 11'b0_0_0_0_0_0_0_01_0_0);
    step("ab.e", 3'd1, 0, 0, 3'd2, 11'b0_0_0_0_0_0_0_01_0_0);
    step("ab.m", 3'd1, 0, 0, 3'd3, 11'b1_0_0_0_0_0_0_01_0_0);
    rst = 1'b1;
    step("ab.rst", 3'd1, 0, 1, 3'd3, 11'b0_0_0_0_0_0_0_00_0_0);
    rst = 1'b0;
    step("ab.after", 3'd1, 0, 0, 3'd0, 11'b1_0_1_0_0_0_0_01_0_0);

    // Long FETCH stall: ab.after already consumed one stalled edge
`ifdef STALL_TIMEOUT_EN
    for (int i = 1; i < 255; i++) begin
      op = 3'd1; rdy = 1'b0;
      @(posedge clk); #1;
    end
    #1;
    chk("tmo.pre.state", {29'd0, state}, 32'd0);
    chk("tmo.pre.trap", {31'd0, trap}, 32'd0);
    @(posedge clk); #1;
    chk("tmo.state", {29'd0, state}, 32'd5);
    chk("tmo.outs", {21'd0, outs}, {21'd0, 11'b0_0_0_0_0_0_0_01_0_1});
`else
    for (int i = 1; i < 300; i++) begin
      op = 3'd1; rdy = 1'b0;
      @(posedge clk); #1;
    end
    #1;
    chk("stall.state", {29'd0, state}, 32'd0);
    chk("stall.outs", {21'd0, outs}, {21'd0, 11'b1_0_1_0_0_0_0_01_0_0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
